thermo_sample_ctrl: RTL and testbench
=====================================

# thermo_sample_ctrl

Periodic acquisition controller that sequences the 1 MHz thermocouple SPI master. It fires a transaction every `SAMPLE_PERIOD` cycles and watches the master's busy handshake with a timeout. It decodes the 14-bit frame into temperature and fault fields and presents each sample on a valid/ready port to the data-logger storage path, counting samples dropped for backpressure.

## Interface
Parameters:
- `SAMPLE_PERIOD`, 25_000_000: cycles between acquisitions (250 ms at 100 MHz; must be ≥ 4096).
- `TIMEOUT`, 8192: cycles allowed from `spi_start` to completion before abort.
- `SEQ_W`, 16: width of the sample sequence number.

Ports:
- `clk`, in, 1: 100 MHz system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: level; permits acquisitions.
- `spi_start`, out, 1: one-cycle start pulse to the SPI master.
- `spi_busy`, in, 1: SPI master busy flag.
- `spi_dout`, in, 16: SPI master receive word; frame occupies bits [13:0].
- `sample_valid`, out, 1: output sample held.
- `sample_ready`, in, 1: consumer accepts.
- `sample_temp`, out, 12: temperature code, `spi_dout[13:2]`, 0.25 °C/LSB.
- `sample_fault`, out, 1: open-thermocouple flag, `spi_dout[0]`.
- `sample_seq`, out, `SEQ_W`: sequence number of the presented sample.
- `err_timeout`, out, 1: sticky; set on any aborted transaction.
- `drop_cnt`, out, 8: saturating count of samples lost to backpressure.

## Operation
- Reset: all outputs 0, state `IDLE`, timer 0, `sample_seq` 0.
- Period timer:
  - Counts only while `enable`=1 and clears while `enable`=0.
  - The first tick occurs `SAMPLE_PERIOD` cycles after `enable` rises, then every `SAMPLE_PERIOD` cycles.
  - A tick arriving outside `WAIT_TICK` is discarded.
- FSM:
  - `IDLE` → `WAIT_TICK` when `enable`=1.
  - `WAIT_TICK`: on tick → `KICK`; on `enable`=0 → `IDLE`.
  - `KICK`: drive `spi_start`=1 for exactly this cycle, clear the timeout counter → `ARMED`.
  - `ARMED`: on `spi_busy`=1 → `XFER`.
  - `XFER`: on `spi_busy`=0 → `CAPTURE`.
  - `CAPTURE`: decode `spi_dout` into the holding register (see below) → `WAIT_TICK`, or → `IDLE` if `enable`=0.
  - The timeout counter runs in `ARMED` and `XFER`. When it reaches `TIMEOUT`, set `err_timeout`, emit no sample, and go to `WAIT_TICK`.
- Output holding register (one entry):
  - Capture with `sample_valid`=0: load the fields and set `valid`.
  - Capture with `valid`=1 and `sample_ready`=0: drop the new sample; `drop_cnt` += 1, saturating at 255.
  - Capture with `valid`=1 and `sample_ready`=1: the old sample is accepted and the new one loaded; `valid` stays 1.
  - Ready without capture: `valid` clears.
  - Output fields remain stable while `valid`=1 and `ready`=0.
- `sample_seq` increments by 1 on each loaded sample and wraps modulo 2^`SEQ_W`. Dropped samples do not increment it.
- `enable`=0 mid-transaction: the transaction completes and its sample is delivered, because the SPI master cannot be aborted.
- `err_timeout` is cleared only by `rst`.

## Timing
- `spi_start` asserts 1 cycle after the tick.
- A capture occurs 1 cycle after `spi_busy` falls. `sample_valid` rises on the following edge.
- A nominal transaction is about 1.5–1.7k cycles, well under `TIMEOUT`.
- Only one transaction is ever outstanding.

## Configuration
- `THERMO_SAMPLE_AVG_EN` defined:
  - Accumulate 4 consecutive non-fault captures in a 14-bit accumulator, then load `acc[13:2]` as `sample_temp`.
  - A fault capture clears the accumulator and loads immediately with `sample_fault`=1 and `sample_temp` = raw value.
  - A timeout also clears the accumulator.
- Undefined: every capture loads directly with no accumulator logic.

## Structure
- `thermo_pkg`: FSM state enum, frame field bit positions (`TEMP_MSB`=13, `TEMP_LSB`=2, `FAULT_BIT`=0), averaging depth constant 4.
- Sub-module `sample_tick_gen`: the period counter. Inputs `clk`, `rst`, `enable`; output `tick`; parameter `SAMPLE_PERIOD`.

## Test plan
- Basic acquisition:
  - Stimulus: `SAMPLE_PERIOD`=5000, behavioural master returns `spi_dout`=16'h0C84, `ready` tied 1.
  - Required: `sample_temp`=12'h321, `sample_fault`=0, `sample_seq`=0 then 1 on the next sample.
- Fault decode:
  - Stimulus: `spi_dout`=16'h0001.
  - Required: `sample_fault`=1, `sample_temp`=0.
- Timeout:
  - Stimulus: the master never raises `spi_busy`.
  - Required: `err_timeout`=1 after 8192 cycles, no `sample_valid`, next tick issues a new `spi_start`.
- Backpressure:
  - Stimulus: `ready`=0 for 3 periods.
  - Required: first sample held stable, `drop_cnt`=2; raising `ready` together with a capture loads the new sample with `valid` continuous.
- Disable mid-transfer:
  - Stimulus: drop `enable` during `XFER`.
  - Required: sample still delivered, FSM returns to `IDLE`, no further `spi_start`.
- With `THERMO_SAMPLE_AVG_EN`:
  - Stimulus: captures with temp codes 100, 102, 104, 106.
  - Required: a single sample with temp 103.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared types and constants for the thermocouple acquisition controller.
package thermo_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StKick,
    StArmed,
    StXfer,
    StCapture
  } state_t;

  // Frame layout inside the 16-bit SPI receive word
  localparam int unsigned TEMP_MSB  = 13;
  localparam int unsigned TEMP_LSB  = 2;
  localparam int unsigned FAULT_BIT = 0;

  // Number of captures averaged when averaging is built in
  localparam int unsigned AVG_DEPTH = 4;

  function automatic logic [11:0] frame_temp(input logic [15:0] word);
    return word[TEMP_MSB:TEMP_LSB];
  endfunction

  function automatic logic frame_fault(input logic [15:0] word);
    return word[FAULT_BIT];
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Period counter: one-cycle tick every SAMPLE_PERIOD cycles of continuous enable.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_PERIOD = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(SAMPLE_PERIOD);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == CW'(SAMPLE_PERIOD - 1));

  // Free-running period count, held at zero while disabled
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/thermo_sample_ctrl.sv
// Periodic thermocouple acquisition controller: kicks the SPI master, guards the
// transfer with a timeout, decodes the frame and presents it on a valid/ready port.
// Optional build macro THERMO_SAMPLE_AVG_EN averages 4 non-fault captures per sample.
module thermo_sample_ctrl
  import thermo_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD = 25_000_000,
  parameter int unsigned TIMEOUT       = 8192,
  parameter int unsigned SEQ_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             spi_start,
  input  logic             spi_busy,
  input  logic [15:0]      spi_dout,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic [11:0]      sample_temp,
  output logic             sample_fault,
  output logic [SEQ_W-1:0] sample_seq,
  output logic             err_timeout,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned TO_W = $clog2(TIMEOUT);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [11:0]      temp_q, temp_d;
  logic             fault_q, fault_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] next_seq_q, next_seq_d;
  logic [7:0]       drop_q, drop_d;

  logic        tick;
  logic        capture;
  logic        timeout_hit;
  logic        load;
  logic [11:0] ld_temp;
  logic        ld_fault;
  logic [11:0] raw_temp;
  logic        raw_fault;
  logic        unused_bits;

  sample_tick_gen #(
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign raw_temp    = frame_temp(spi_dout);
  assign raw_fault   = frame_fault(spi_dout);
  assign unused_bits = ^{spi_dout[15:14], spi_dout[1]};

  assign capture     = (state_q == StCapture);
  assign timeout_hit = ((state_q == StArmed) || (state_q == StXfer)) &&
                       (to_cnt_q == TO_W'(TIMEOUT - 1));

  // Sequencer next state, start pulse, timeout counter and sticky error
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
    spi_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StWaitTick;
      end
      StWaitTick: begin
        if (tick)         state_d = StKick;
        else if (!enable) state_d = StIdle;
      end
      StKick: begin
        spi_start = 1'b1;
        to_cnt_d  = '0;
        state_d   = StArmed;
      end
      StArmed, StXfer: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StWaitTick;
        end else if ((state_q == StArmed) && spi_busy) begin
          state_d = StXfer;
        end else if ((state_q == StXfer) && !spi_busy) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        state_d = enable ? StWaitTick : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef THERMO_SAMPLE_AVG_EN
  logic [13:0] acc_q, acc_d;
  logic [1:0]  avg_n_q, avg_n_d;
  logic [13:0] acc_sum;
  logic        unused_acc;

  assign acc_sum    = acc_q + {2'b00, raw_temp};
  assign unused_acc = ^acc_sum[1:0];

  // Averaging: faults bypass the accumulator, timeouts discard partial sums
  always_comb begin
    acc_d    = acc_q;
    avg_n_d  = avg_n_q;
    load     = 1'b0;
    ld_temp  = raw_temp;
    ld_fault = 1'b0;
    if (capture) begin
      if (raw_fault) begin
        load     = 1'b1;
        ld_fault = 1'b1;
        acc_d    = '0;
        avg_n_d  = '0;
      end else if (avg_n_q == 2'(AVG_DEPTH - 1)) begin
        load    = 1'b1;
        ld_temp = acc_sum[13:2];
        acc_d   = '0;
        avg_n_d = '0;
      end else begin
        acc_d   = acc_sum;
        avg_n_d = avg_n_q + 2'd1;
      end
    end
    if (timeout_hit) begin
      acc_d   = '0;
      avg_n_d = '0;
    end
  end

  // Accumulator state
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      avg_n_q <= '0;
    end else begin
      acc_q   <= acc_d;
      avg_n_q <= avg_n_d;
    end
  end
`else
  // Every capture becomes a sample
  always_comb begin
    load     = capture;
    ld_temp  = raw_temp;
    ld_fault = raw_fault;
  end
`endif

  // One-entry holding register with drop accounting
  always_comb begin
    valid_d    = valid_q;
    temp_d     = temp_q;
    fault_d    = fault_q;
    seq_d      = seq_q;
    next_seq_d = next_seq_q;
    drop_d     = drop_q;
    if (load) begin
      if (!valid_q || sample_ready) begin
        valid_d    = 1'b1;
        temp_d     = ld_temp;
        fault_d    = ld_fault;
        seq_d      = next_seq_q;
        next_seq_d = next_seq_q + SEQ_W'(1);
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (sample_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      temp_q     <= '0;
      fault_q    <= 1'b0;
      seq_q      <= '0;
      next_seq_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      temp_q     <= temp_d;
      fault_q    <= fault_d;
      seq_q      <= seq_d;
      next_seq_q <= next_seq_d;
      drop_q     <= drop_d;
    end
  end

  assign sample_valid = valid_q;
  assign sample_temp  = temp_q;
  assign sample_fault = fault_q;
  assign sample_seq   = seq_q;
  assign err_timeout  = err_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_thermo_sample_ctrl.sv
// Directed bench for thermo_sample_ctrl (default build, averaging disabled).
module tb_thermo_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        spi_start;
  logic        spi_busy = 1'b0;
  logic [15:0] spi_dout = 16'h0000;
  logic        sample_valid;
  logic        sample_ready;
  logic [11:0] sample_temp;
  logic        sample_fault;
  logic [15:0] sample_seq;
  logic        err_timeout;
  logic [7:0]  drop_cnt;

  int          total = 0;
  int          bad = 0;
  int          start_cnt = 0;
  logic        mute = 1'b0;
  logic [15:0] dout_val = 16'h0C84;

  thermo_sample_ctrl #(
    .SAMPLE_PERIOD (5000),
    .TIMEOUT       (8192),
    .SEQ_W         (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .spi_start    (spi_start),
    .spi_busy     (spi_busy),
    .spi_dout     (spi_dout),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_temp  (sample_temp),
    .sample_fault (sample_fault),
    .sample_seq   (sample_seq),
    .err_timeout  (err_timeout),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural SPI master: short busy window, result word appears as busy falls
  initial forever begin
    @(negedge clk);
    if (spi_start === 1'b1 && !mute) begin
      repeat (4) @(negedge clk);
      spi_busy = 1'b1;
      repeat (100) @(negedge clk);
      spi_dout = dout_val;
      spi_busy = 1'b0;
    end
  end

  always @(negedge clk) if (spi_start === 1'b1) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (sample_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, {31'd0, sample_valid}, 32'd1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n = 0;
    while (spi_start !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, {31'd0, spi_start}, 32'd1);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (spi_busy !== lvl && n < budget) begin
      step();
      n++;
    end
    chk(tag, {31'd0, spi_busy}, {31'd0, lvl});
  endtask

  initial begin
    int s0;
    int viol;
    int n;
    logic seen;

    rst = 1'b1;
    enable = 1'b0;
    sample_ready = 1'b1;
    repeat (5) step();
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_start", {31'd0, spi_start}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk("rst_seq", {16'd0, sample_seq}, 32'd0);
    chk("rst_temp", {20'd0, sample_temp}, 32'd0);
    rst = 1'b0;
    step();
    enable = 1'b1;

    // Basic acquisition
    wait_valid(6000, "basic0_valid");
    chk("basic0_temp", {20'd0, sample_temp}, 32'h321);
    chk("basic0_fault", {31'd0, sample_fault}, 32'd0);
    chk("basic0_seq", {16'd0, sample_seq}, 32'd0);
    chk("basic0_starts", start_cnt, 32'd1);
    step();
    chk("basic0_consumed", {31'd0, sample_valid}, 32'd0);
    wait_valid(6000, "basic1_valid");
    chk("basic1_temp", {20'd0, sample_temp}, 32'h321);
    chk("basic1_seq", {16'd0, sample_seq}, 32'd1);

    // Fault decode
    dout_val = 16'h0001;
    step();
    wait_valid(6000, "fault_valid");
    chk("fault_flag", {31'd0, sample_fault}, 32'd1);
    chk("fault_temp", {20'd0, sample_temp}, 32'd0);
    chk("fault_seq", {16'd0, sample_seq}, 32'd2);

    // Timeout: master ignores the start
    mute = 1'b1;
    step();
    wait_start(6000, "to_start");
    s0 = start_cnt;
    seen = 1'b0;
    for (int i = 0; i < 8100; i++) begin
      step();
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    chk("to_err_early", {31'd0, err_timeout}, 32'd0);
    for (int i = 0; i < 200; i++) begin
      step();
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    chk("to_err_set", {31'd0, err_timeout}, 32'd1);
    chk("to_no_sample", {31'd0, seen}, 32'd0);
    mute = 1'b0;
    dout_val = 16'h0C84;
    wait_start(6000, "to_restart");
    chk("to_restart_cnt", start_cnt, s0 + 1);
    wait_valid(500, "to_recover_valid");
    chk("to_recover_seq", {16'd0, sample_seq}, 32'd3);
    chk("to_recover_temp", {20'd0, sample_temp}, 32'h321);
    step();
    chk("to_recover_consumed", {31'd0, sample_valid}, 32'd0);

    // Backpressure
    sample_ready = 1'b0;
    dout_val = 16'h0010;
    wait_valid(6000, "bp_first_valid");
    chk("bp_first_temp", {20'd0, sample_temp}, 32'd4);
    chk("bp_first_seq", {16'd0, sample_seq}, 32'd4);
    dout_val = 16'h0020;
    viol = 0;
    n = 0;
    while (drop_cnt !== 8'd2 && n < 12000) begin
      step();
      n++;
      if (sample_valid !== 1'b1 || sample_temp !== 12'd4 || sample_seq !== 16'd4) viol++;
    end
    chk("bp_drop", {24'd0, drop_cnt}, 32'd2);
    chk("bp_stable", viol, 32'd0);
    dout_val = 16'h0030;
    wait_busy(1'b1, 6000, "bp_busy_rise");
    wait_busy(1'b0, 500, "bp_busy_fall");
    step();
    chk("bp_held_before", {31'd0, sample_valid}, 32'd1);
    chk("bp_held_temp", {20'd0, sample_temp}, 32'd4);
    sample_ready = 1'b1;
    step();
    chk("bp_swap_valid", {31'd0, sample_valid}, 32'd1);
    chk("bp_swap_temp", {20'd0, sample_temp}, 32'd12);
    chk("bp_swap_seq", {16'd0, sample_seq}, 32'd5);
    chk("bp_swap_drop", {24'd0, drop_cnt}, 32'd2);
    step();
    chk("bp_swap_consumed", {31'd0, sample_valid}, 32'd0);

    // Disable mid-transfer
    dout_val = 16'h0C84;
    wait_busy(1'b1, 6000, "dis_busy_rise");
    repeat (5) step();
    enable = 1'b0;
    wait_valid(500, "dis_valid");
    chk("dis_temp", {20'd0, sample_temp}, 32'h321);
    chk("dis_seq", {16'd0, sample_seq}, 32'd6);
    s0 = start_cnt;
    seen = 1'b0;
    step();
    for (int i = 0; i < 12000; i++) begin
      step();
      if (sample_valid === 1'b1) seen = 1'b1;
    end
    chk("dis_no_start", start_cnt, s0);
    chk("dis_no_sample", {31'd0, seen}, 32'd0);
    chk("dis_err_sticky", {31'd0, err_timeout}, 32'd1);
    chk("dis_drop_kept", {24'd0, drop_cnt}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
